matrix_frame_sequencer: RTL and testbench
=========================================

Name: matrix_frame_sequencer

Overview:
Parametrised frame sequencer that streams one full LED-matrix image from a synchronous frame buffer into output_module. It generalises the fixed 3-channel, 384-byte test sequencer to arbitrary channel count, column count and bytes per column. It also adds per-column start pulses, the last-byte extra_bit, frame-done reporting and a busy-handshake timeout. It sits between the HDMI-fed frame buffer and output_module.

Parameters:
CHANNEL_NUMBER, 3, parallel SPI channels; one frame-buffer byte lane per channel.
SPI_SIZE, 8, bits per data word per channel.
COLUMNS, 8, columns per image, driven one after another through the shift register.
BYTES_PER_COLUMN, 48, data words per channel per column.
TIMEOUT_CYCLES, 4096, maximum cycles to wait on any tx_finish edge before aborting.
ADDR_W, $clog2(COLUMNS*BYTES_PER_COLUMN), frame-buffer address width (derived).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
frame_start  in  1  one-cycle request to send a frame; ignored unless idle
rd_addr  out  ADDR_W  frame-buffer read address (column*BYTES_PER_COLUMN + byte)
rd_en  out  1  frame-buffer read strobe
rd_data  in  CHANNEL_NUMBER*SPI_SIZE  read data, valid exactly 1 cycle after rd_en
data_in  out  CHANNEL_NUMBER x SPI_SIZE  words to output_module, held stable from next_data until the next fetch
start_first_column  out  1  pulse to output_module, start of frame
start_next_column  out  1  pulse to output_module, start of columns 1..COLUMNS-1
next_data  out  1  one-cycle pulse: data_in valid
extra_bit  out  1  1 while the last word of a column is presented, else 0
tx_finish  in  1  from output_module; low = transfer in progress, high = idle/done
busy  out  1  high from accepted frame_start until return to IDLE
column  out  $clog2(COLUMNS)  index of the column being sent
frame_done  out  1  one-cycle pulse on successful frame completion
timeout_err  out  1  sticky error flag; cleared only by reset or accepted frame_start

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; rd_addr, column, byte counter = 0; data_in = 0; all pulse outputs, busy, extra_bit and timeout_err = 0. Reset mid-frame aborts immediately; no further pulses are issued.
- States: IDLE, COL_START, FETCH, LATCH, ISSUE, WAIT_BUSY, WAIT_DONE, COL_END, DONE.
- IDLE: on frame_start, go to COL_START with column=0, byte=0, clear timeout_err, set busy.
- COL_START: pulse start_first_column if column==0, else start_next_column. Go to FETCH.
- FETCH: rd_en=1 for one cycle with rd_addr = column*BYTES_PER_COLUMN+byte. Go to LATCH.
- LATCH: register rd_data into data_in, with channel i taking bits [i*SPI_SIZE +: SPI_SIZE]. Set extra_bit = (byte==BYTES_PER_COLUMN-1). Go to ISSUE.
- ISSUE: next_data=1 for exactly one cycle. Go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_finish==0, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_finish==1. Then, if byte < BYTES_PER_COLUMN-1, increment byte and go to FETCH; otherwise go to COL_END.
- Timeout: while in WAIT_BUSY or WAIT_DONE, a counter reloads on entry. After TIMEOUT_CYCLES cycles without the awaited edge: set timeout_err, go to IDLE, and do not pulse frame_done.
- COL_END: clear extra_bit and byte. If column==COLUMNS-1, go to DONE; else increment column and go to COL_START.
- DONE: frame_done=1 for one cycle, busy=0 on the next cycle, go to IDLE.
- Latency: frame_start to start_first_column is 2 cycles. rd_en to next_data is 2 cycles.
- frame_start while busy is ignored, with no queueing.
- A tx_finish glitch high during WAIT_BUSY is ignored; only the falling edge advances.
- All counters are sized exactly; byte and column never wrap beyond their limits.

Optional Feature:
AUTO_REPEAT_EN.
- Defined: adds an input port repeat_en. In DONE, if repeat_en==1, frame_done still pulses but the state goes directly to COL_START with column=0 and busy stays high, giving a continuous refresh without frame_start. Deasserting repeat_en lets the current frame finish, then the block idles. A timeout still ends in IDLE.
- Undefined: no repeat_en port; every frame needs frame_start.

Test Plan:
- Reset, then hold rst_n=1 for 20 cycles with no stimulus -> busy=0, all pulses 0, rd_en never asserted.
- COLUMNS=2, BYTES_PER_COLUMN=3, CHANNEL_NUMBER=3; buffer word k = {k,k+64,k+128}; tx_finish model gives 4 busy cycles per word -> rd_addr sequence 0..5. data_in[0] sequence 0..5, data_in[2] sequence 128..133. One start_first_column, one start_next_column, extra_bit=1 on words 2 and 5 only, and frame_done after the 6th tx_finish rise.
- Same setup with frame_start pulsed again mid-frame -> no effect; exactly 6 next_data pulses in total.
- TIMEOUT_CYCLES=16; tx_finish held 1 after the first next_data -> timeout_err=1 at cycle 16 of WAIT_BUSY, busy=0, no frame_done. The next frame_start clears timeout_err.
- rst_n=0 while in WAIT_DONE of column 1 -> next cycle all outputs at reset values, state IDLE.
- With AUTO_REPEAT_EN and repeat_en=1 for 2.5 frames -> 3 frame_done pulses, busy stays continuously high, and the frame following each frame_done begins with start_first_column.

Source files
------------

// File: rtl/matrix_frame_sequencer.sv
// Streams one LED-matrix image, column by column, from a synchronous frame buffer into output_module.
// Optional macro AUTO_REPEAT_EN adds a repeat_en input for continuous refresh without frame_start.
module matrix_frame_sequencer #(
    parameter int CHANNEL_NUMBER   = 3,
    parameter int SPI_SIZE         = 8,
    parameter int COLUMNS          = 8,
    parameter int BYTES_PER_COLUMN = 48,
    parameter int TIMEOUT_CYCLES   = 4096,
    parameter int ADDR_W           = $clog2(COLUMNS * BYTES_PER_COLUMN),
    localparam int COL_W           = (COLUMNS > 1) ? $clog2(COLUMNS) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frame_start,
    output logic [ADDR_W-1:0]                  rd_addr,
    output logic                               rd_en,
    input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
    output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_in,
    output logic                               start_first_column,
    output logic                               start_next_column,
    output logic                               next_data,
    output logic                               extra_bit,
    input  logic                               tx_finish,
    output logic                               busy,
    output logic [COL_W-1:0]                   column,
    output logic                               frame_done,
    output logic                               timeout_err
`ifdef AUTO_REPEAT_EN
    ,
    input  logic                               repeat_en
`endif
);

    localparam int BYTE_W = (BYTES_PER_COLUMN > 1) ? $clog2(BYTES_PER_COLUMN) : 1;
    localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_COLUMN - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLUMNS - 1);
    localparam logic [TMR_W-1:0]  LAST_TICK = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_COL_START,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_COL_END,
        S_DONE
    } state_t;

    state_t                             state_q, state_d;
    logic [COL_W-1:0]                   col_q, col_d;
    logic [BYTE_W-1:0]                  byte_q, byte_d;
    logic [TMR_W-1:0]                   timer_q, timer_d;
    logic                               timeout_set;
    logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_q;
    logic                               extra_q;
    logic                               err_q;
    logic                               sfc_q;
    logic                               snc_q;

    // State register plus the small datapath registers that follow it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            byte_q  <= '0;
            timer_q <= '0;
            data_q  <= '0;
            extra_q <= 1'b0;
            err_q   <= 1'b0;
            sfc_q   <= 1'b0;
            snc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            byte_q  <= byte_d;
            timer_q <= timer_d;
            sfc_q   <= (state_q == S_COL_START) && (col_q == '0);
            snc_q   <= (state_q == S_COL_START) && (col_q != '0);

            // Buffer lane i maps straight onto channel i, so a plain copy keeps the packing.
            if (state_q == S_LATCH) begin
                data_q  <= rd_data;
                extra_q <= (byte_q == LAST_BYTE);
            end else if (state_q == S_COL_END) begin
                extra_q <= 1'b0;
            end

            if (state_q == S_IDLE && frame_start) begin
                err_q <= 1'b0;
            end else if (timeout_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state logic; the timeout timer restarts from zero on every state change.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        col_d       = col_q;
        byte_d      = byte_q;
        timer_d     = '0;
        timeout_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_COL_START;
                    col_d   = '0;
                    byte_d  = '0;
                end
            end
            S_COL_START: state_d = S_FETCH;
            S_FETCH:     state_d = S_LATCH;
            S_LATCH:     state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!tx_finish) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == LAST_TICK) begin
                    state_d     = S_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tx_finish) begin
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + BYTE_W'(1);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_COL_END;
                    end
                end else if (timer_q == LAST_TICK) begin
                    state_d     = S_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_COL_END: begin
                byte_d = '0;
                if (col_q == LAST_COL) begin
                    state_d = S_DONE;
                end else begin
                    col_d   = col_q + COL_W'(1);
                    state_d = S_COL_START;
                end
            end
            S_DONE: begin
`ifdef AUTO_REPEAT_EN
                if (repeat_en) begin
                    state_d = S_COL_START;
                    col_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state and counters.
    always_comb begin
        rd_en              = (state_q == S_FETCH);
        rd_addr            = ADDR_W'(col_q) * ADDR_W'(BYTES_PER_COLUMN) + ADDR_W'(byte_q);
        next_data          = (state_q == S_ISSUE);
        frame_done         = (state_q == S_DONE);
        busy               = (state_q != S_IDLE);
        column             = col_q;
        data_in            = data_q;
        extra_bit          = extra_q;
        timeout_err        = err_q;
        start_first_column = sfc_q;
        start_next_column  = snc_q;
    end

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Directed bench for matrix_frame_sequencer: 2 columns x 3 words x 3 channels, 16-cycle timeout.
// Frame-buffer and output_module behaviour are modelled here; repeat mode is exercised when AUTO_REPEAT_EN is defined.
module tb_matrix_frame_sequencer;

    localparam int CH  = 3;
    localparam int SPI = 8;
    localparam int COL = 2;
    localparam int BPC = 3;
    localparam int TMO = 16;
    localparam int AW  = $clog2(COL * BPC);

    logic              clk;
    logic              rst_n;
    logic              frame_start;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic [CH*SPI-1:0] rd_data;
    logic [CH*SPI-1:0] data_in;
    logic              start_first_column;
    logic              start_next_column;
    logic              next_data;
    logic              extra_bit;
    logic              tx_finish;
    logic              busy;
    logic [0:0]        column;
    logic              frame_done;
    logic              timeout_err;
`ifdef AUTO_REPEAT_EN
    logic              repeat_en;
`endif

    matrix_frame_sequencer #(
        .CHANNEL_NUMBER  (CH),
        .SPI_SIZE        (SPI),
        .COLUMNS         (COL),
        .BYTES_PER_COLUMN(BPC),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_start       (frame_start),
        .rd_addr           (rd_addr),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .data_in           (data_in),
        .start_first_column(start_first_column),
        .start_next_column (start_next_column),
        .next_data         (next_data),
        .extra_bit         (extra_bit),
        .tx_finish         (tx_finish),
        .busy              (busy),
        .column            (column),
        .frame_done        (frame_done),
        .timeout_err       (timeout_err)
`ifdef AUTO_REPEAT_EN
        ,
        .repeat_en         (repeat_en)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame buffer: word k holds k, k+64, k+128 on channels 0, 1, 2.
    function automatic logic [23:0] word(input int k);
        return {8'(k + 128), 8'(k + 64), 8'(k)};
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= word(int'(rd_addr));
    end

    // output_module: drops tx_finish while next_data is seen, holds it low for 4 cycles.
    logic tx_en;
    int   tx_rem = 0;
    initial tx_finish = 1'b1;
    always @(posedge clk) begin
        #1;
        if (tx_en && next_data) begin
            tx_finish = 1'b0;
            tx_rem    = 4;
        end else if (tx_rem > 0) begin
            tx_rem--;
            if (tx_rem == 0) tx_finish = 1'b1;
        end
    end

    // Event monitor with cumulative counters; the main sequence compares deltas.
    int       n_rd = 0, n_nd = 0, n_sfc = 0, n_snc = 0, n_fd = 0, n_rise = 0;
    int       fd_rise = 0, n_bfall = 0, n_order = 0;
    logic     tx_prev = 1'b1, busy_prev = 1'b0, after_done = 1'b0;
    logic [7:0] addr_log[64];
    logic [7:0] d0_log[64];
    logic [7:0] d2_log[64];
    logic       xb_log[64];

    always @(negedge clk) begin
        if (rd_en) begin
            addr_log[n_rd % 64] = 8'(rd_addr);
            n_rd++;
        end
        if (next_data) begin
            d0_log[n_nd % 64] = data_in[7:0];
            d2_log[n_nd % 64] = data_in[23:16];
            xb_log[n_nd % 64] = extra_bit;
            n_nd++;
        end
        if (tx_finish && !tx_prev) n_rise++;
        tx_prev = tx_finish;
        if (busy_prev && !busy) n_bfall++;
        busy_prev = busy;
        if (start_first_column) begin
            n_sfc++;
            after_done = 1'b0;
        end
        if (start_next_column) begin
            n_snc++;
            if (after_done) n_order++;
        end
        if (frame_done) begin
            n_fd++;
            fd_rise    = n_rise;
            after_done = 1'b1;
        end
    end

    int b_rd, b_nd, b_sfc, b_snc, b_fd, b_rise, b_bfall;

    task automatic snap();
        b_rd    = n_rd;
        b_nd    = n_nd;
        b_sfc   = n_sfc;
        b_snc   = n_snc;
        b_fd    = n_fd;
        b_rise  = n_rise;
        b_bfall = n_bfall;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int i = 0;
        while (busy && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        tx_en       = 1'b1;
`ifdef AUTO_REPEAT_EN
        repeat_en   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);

        // Idle with no stimulus.
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rd_count", 32'(n_rd), 32'd0);
        check("idle_pulses", 32'(n_sfc + n_snc + n_nd + n_fd), 32'd0);
        check("idle_err", 32'(timeout_err), 32'd0);

        // Full frame with 2-cycle start latency.
        snap();
        pulse_start();
        check("lat_sfc_early", 32'(start_first_column), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_sfc", 32'(start_first_column), 32'd1);
        check("lat_rd_en", 32'(rd_en), 32'd1);
        wait_idle(300, "f1_idle");
        check("f1_rd_count", 32'(n_rd - b_rd), 32'd6);
        check("f1_nd_count", 32'(n_nd - b_nd), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("f1_addr%0d", i), 32'(addr_log[(b_rd + i) % 64]), 32'(i));
            check($sformatf("f1_d0_%0d", i), 32'(d0_log[(b_nd + i) % 64]), 32'(i));
            check($sformatf("f1_d2_%0d", i), 32'(d2_log[(b_nd + i) % 64]), 32'(128 + i));
            check($sformatf("f1_xb%0d", i), 32'(xb_log[(b_nd + i) % 64]), (i == 2 || i == 5) ? 32'd1 : 32'd0);
        end
        check("f1_sfc", 32'(n_sfc - b_sfc), 32'd1);
        check("f1_snc", 32'(n_snc - b_snc), 32'd1);
        check("f1_fd", 32'(n_fd - b_fd), 32'd1);
        check("f1_fd_after_rise", 32'(fd_rise - b_rise), 32'd6);
        check("f1_err", 32'(timeout_err), 32'd0);

        // Second frame_start mid-frame is ignored.
        snap();
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        check("f2_still_busy", 32'(busy), 32'd1);
        wait_idle(300, "f2_idle");
        check("f2_nd_count", 32'(n_nd - b_nd), 32'd6);
        check("f2_sfc", 32'(n_sfc - b_sfc), 32'd1);
        check("f2_fd", 32'(n_fd - b_fd), 32'd1);
        repeat (5) @(negedge clk);
        check("f2_no_restart", 32'(busy), 32'd0);

        // Timeout: tx_finish never drops after the first word.
        tx_en = 1'b0;
        snap();
        pulse_start();
        begin
            int i = 0;
            while (!next_data && i < 50) begin
                @(negedge clk);
                i++;
            end
            check("to_first_nd", 32'(next_data), 32'd1);
        end
        repeat (16) @(negedge clk);
        check("to_err_not_yet", 32'(timeout_err), 32'd0);
        check("to_busy_waiting", 32'(busy), 32'd1);
        @(negedge clk);
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_busy_drop", 32'(busy), 32'd0);
        check("to_no_fd", 32'(n_fd - b_fd), 32'd0);
        repeat (5) @(negedge clk);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        tx_en = 1'b1;
        snap();
        pulse_start();
        check("to_err_cleared", 32'(timeout_err), 32'd0);
        wait_idle(300, "to_recover_idle");
        check("to_recover_fd", 32'(n_fd - b_fd), 32'd1);

        // Reset while waiting on the first word of column 1.
        snap();
        pulse_start();
        begin
            int i = 0;
            while (!(next_data && column == 1'b1) && i < 200) begin
                @(negedge clk);
                i++;
            end
            check("rs_reach_col1", 32'(column), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_column", 32'(column), 32'd0);
        check("rs_rd_addr", 32'(rd_addr), 32'd0);
        check("rs_data_in", 32'(data_in), 32'd0);
        check("rs_pulses", 32'({rd_en, next_data, start_first_column, start_next_column, frame_done}), 32'd0);
        check("rs_flags", 32'({extra_bit, timeout_err}), 32'd0);
        rst_n = 1'b1;
        snap();
        repeat (15) @(negedge clk);
        check("rs_quiet_nd", 32'(n_nd - b_nd), 32'd0);
        check("rs_quiet_fd", 32'(n_fd - b_fd), 32'd0);

`ifdef AUTO_REPEAT_EN
        // Continuous refresh for 2.5 frames.
        snap();
        begin
            int rep_order = n_order;
            repeat_en = 1'b1;
            pulse_start();
            begin
                int i = 0;
                while ((n_fd - b_fd) < 2 && i < 400) begin
                    @(negedge clk);
                    i++;
                end
                check("rp_two_frames", 32'(n_fd - b_fd), 32'd2);
            end
            repeat (20) @(negedge clk);
            check("rp_busy_held", 32'(n_bfall - b_bfall), 32'd0);
            repeat_en = 1'b0;
            wait_idle(300, "rp_idle");
            check("rp_fd", 32'(n_fd - b_fd), 32'd3);
            check("rp_sfc", 32'(n_sfc - b_sfc), 32'd3);
            check("rp_busy_falls", 32'(n_bfall - b_bfall), 32'd1);
            check("rp_order", 32'(n_order - rep_order), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
